// File: rtl/anode_scan_driver.sv
// Four-digit active-low anode scanner with programmable dwell and circular skip of disabled digits.
// Optional all-off gap between digits when SCAN_BLANKING_EN is defined.
module anode_scan_driver #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] digit_en,
  output logic [3:0] anode,
  output logic [1:0] digit_idx,
  output logic       frame_tick
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);

  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("anode_scan_driver: REFRESH_DIV must be >= 2");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("anode_scan_driver: BLANK_CYCLES must be >= 1");
  end

`ifdef SCAN_BLANKING_EN
  localparam int unsigned BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  typedef enum logic [1:0] {ST_OFF, ST_SHOW, ST_BLANK} state_t;
`else
  typedef enum logic [1:0] {ST_OFF, ST_SHOW} state_t;
`endif

  state_t        state;
  logic [CW-1:0] cnt;
`ifdef SCAN_BLANKING_EN
  logic [BW-1:0] bcnt;
  logic          wrap_pend;
`endif

  // First enabled position found circularly after cur; cur itself if it is the only one.
  function automatic logic [1:0] next_idx(input logic [1:0] cur, input logic [3:0] en);
    logic [1:0] cand;
    next_idx = cur;
    for (int k = 4; k >= 1; k--) begin
      cand = cur + 2'(k);
      if (en[cand]) next_idx = cand;
    end
  endfunction

  function automatic logic [3:0] sel(input logic [1:0] i);
    return ~(4'b0001 << i);
  endfunction

  logic [1:0] nxt_idx_c;
  logic [1:0] first_idx_c;
  logic       wrap_c;
  logic       abort_c;

  assign nxt_idx_c   = next_idx(digit_idx, digit_en);
  assign first_idx_c = next_idx(2'd3, digit_en);
  assign wrap_c      = (nxt_idx_c <= digit_idx);
  assign abort_c     = !enable || (digit_en == 4'b0000);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_OFF;
      anode      <= 4'b1111;
      digit_idx  <= 2'd0;
      frame_tick <= 1'b0;
      cnt        <= '0;
`ifdef SCAN_BLANKING_EN
      bcnt       <= '0;
      wrap_pend  <= 1'b0;
`endif
    end else begin
      frame_tick <= 1'b0;
      if (abort_c) begin
        state <= ST_OFF;
        anode <= 4'b1111;
        cnt   <= '0;
      end else begin
        case (state)
          ST_OFF: begin
            state     <= ST_SHOW;
            digit_idx <= first_idx_c;
            anode     <= sel(first_idx_c);
            cnt       <= '0;
          end
          ST_SHOW: begin
            if (!digit_en[digit_idx]) begin
              // Current digit withdrawn: move on immediately, no blanking gap.
              digit_idx  <= nxt_idx_c;
              anode      <= sel(nxt_idx_c);
              cnt        <= '0;
              frame_tick <= wrap_c;
            end else if (cnt == CW'(REFRESH_DIV - 1)) begin
              cnt       <= '0;
              digit_idx <= nxt_idx_c;
`ifdef SCAN_BLANKING_EN
              state     <= ST_BLANK;
              anode     <= 4'b1111;
              bcnt      <= '0;
              wrap_pend <= wrap_c;
`else
              anode      <= sel(nxt_idx_c);
              frame_tick <= wrap_c;
`endif
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
`ifdef SCAN_BLANKING_EN
          ST_BLANK: begin
            // Frame tick is deferred until the wrapped digit actually lights.
            if (bcnt == BW'(BLANK_CYCLES - 1)) begin
              state      <= ST_SHOW;
              anode      <= sel(digit_idx);
              frame_tick <= wrap_pend;
              cnt        <= '0;
            end else begin
              bcnt <= bcnt + BW'(1);
            end
          end
`endif
          default: begin
            state <= ST_OFF;
            anode <= 4'b1111;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_anode_scan_driver.sv
// Self-checking bench for anode_scan_driver: directed scenarios then random enables/resets,
// compared each cycle against a dwell-countdown reference model (handles SCAN_BLANKING_EN builds).
module tb_anode_scan_driver;

  localparam int R = 4;
  localparam int B = 2;
`ifdef SCAN_BLANKING_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] digit_en;
  logic [3:0] anode;
  logic [1:0] digit_idx;
  logic       frame_tick;

  int checks   = 0;
  int failures = 0;

  // Reference model: which position is lit and how many cycles of it remain.
  bit m_on, m_tick, m_pend, m_idx_chk;
  int m_idx, m_left, m_blank;

  anode_scan_driver #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digit_en(digit_en),
    .anode(anode), .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic int search(input int cur, input logic [3:0] de);
    for (int k = 1; k <= 4; k++) begin
      if (de[(cur + k) % 4]) return (cur + k) % 4;
    end
    return cur;
  endfunction

  task automatic model(input logic r, input logic e, input logic [3:0] de);
    int n;
    m_tick = 1'b0;
    if (!r) begin
      m_on = 1'b0; m_idx = 0; m_left = 0; m_blank = 0; m_pend = 1'b0; m_idx_chk = 1'b1;
    end else if (!e || de == 4'b0000) begin
      m_on = 1'b0; m_blank = 0; m_idx_chk = 1'b0;
    end else if (!m_on) begin
      m_on = 1'b1; m_idx = search(3, de); m_left = R; m_blank = 0; m_idx_chk = 1'b1;
    end else if (m_blank > 0) begin
      m_blank = m_blank - 1;
      if (m_blank == 0) begin
        m_left = R;
        m_tick = m_pend;
      end
    end else if (!de[m_idx] || m_left == 1) begin
      n = search(m_idx, de);
      if (de[m_idx] && BLANK_ON) begin
        m_blank = B;
        m_pend  = (n <= m_idx);
      end else begin
        m_tick = (n <= m_idx);
      end
      m_idx  = n;
      m_left = R;
    end else begin
      m_left = m_left - 1;
    end
  endtask

  task automatic check(input string tag);
    logic [3:0] one;
    logic [3:0] exp_a;
    one   = 4'b0001 << m_idx;
    exp_a = (m_on && m_blank == 0) ? ~one : 4'b1111;
    checks++;
    assert (anode === exp_a) else begin
      failures++;
      $error("FAIL %s anode obs=%b exp=%b", tag, anode, exp_a);
    end
    checks++;
    assert (frame_tick === m_tick) else begin
      failures++;
      $error("FAIL %s frame_tick obs=%b exp=%b", tag, frame_tick, m_tick);
    end
    if (m_idx_chk) begin
      checks++;
      assert (digit_idx === 2'(m_idx)) else begin
        failures++;
        $error("FAIL %s digit_idx obs=%0d exp=%0d", tag, digit_idx, m_idx);
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] de, input string tag);
    rst_n = r; enable = e; digit_en = de;
    @(posedge clk);
    model(r, e, de);
    #1;
    check(tag);
  endtask

  initial begin
    logic [3:0] rot [17];
    logic       r, e;
    logic [3:0] de;
    rst_n = 1'b0; enable = 1'b0; digit_en = 4'b0000;
    m_on = 1'b0; m_tick = 1'b0; m_pend = 1'b0; m_idx_chk = 1'b1;
    m_idx = 0; m_left = 0; m_blank = 0;
    for (int i = 0; i < 17; i++) rot[i] = (i < 4) ? 4'b1110 : (i < 8) ? 4'b1101 :
                                          (i < 12) ? 4'b1011 : (i < 16) ? 4'b0111 : 4'b1110;

    repeat (3) step(1'b0, 1'b1, 4'b1111, "reset");

    // Full rotation straight out of reset.
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b1, 4'b1111, "rotate");
      if (!BLANK_ON) begin
        checks++;
        assert (anode === rot[i]) else begin
          failures++;
          $error("FAIL rotate_table[%0d] anode obs=%b exp=%b", i, anode, rot[i]);
        end
      end
    end

    repeat (20) step(1'b1, 1'b1, 4'b0101, "sparse");
    repeat (12) step(1'b1, 1'b1, 4'b1000, "single");

    // Drop enable at dwell cycle 2, then re-enable.
    step(1'b0, 1'b1, 4'b1111, "drop_rst");
    repeat (3) step(1'b1, 1'b1, 4'b1111, "drop_run");
    repeat (2) step(1'b1, 1'b0, 4'b1111, "drop_off");
    repeat (6) step(1'b1, 1'b1, 4'b0110, "reenable");

    // Withdraw digit 1 while it is lit.
    step(1'b0, 1'b1, 4'b1111, "mid_rst");
    repeat (5 + (BLANK_ON ? B : 0)) step(1'b1, 1'b1, 4'b1111, "mid_run");
    step(1'b1, 1'b1, 4'b1101, "mid_clear");
    repeat (4) step(1'b1, 1'b1, 4'b1101, "mid_after");

    // Reset pulse in the gap between digits (or just after the first advance).
    step(1'b0, 1'b1, 4'b1111, "gap_rst");
    repeat (5) step(1'b1, 1'b1, 4'b1111, "gap_run");
    step(1'b0, 1'b1, 4'b1111, "gap_pulse");
    repeat (3) step(1'b1, 1'b1, 4'b1111, "gap_after");

    de = 4'b1111;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 63) != 0);
      e = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) de = 4'($urandom_range(0, 15));
      step(r, e, de, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
